// File: rtl/rom_arbiter.sv
// Two-port arbiter (instruction fetch, load) in front of one combinational ROM read port.
// Load wins conflicts until fetch has lost STARVE_MAX cycles in a row; responses arrive one cycle after grant.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
  // Byte-address bits above the ROM; empty when the ROM spans the whole space.
  localparam logic [31:0] RANGE_MASK =
    (ADDR_WIDTH >= 30) ? 32'h0000_0000 : (~((32'h0000_0001 << ADDR_WIDTH) - 32'h0000_0001)) << 2;

  // Misaligned or beyond the ROM: the access is answered with an error instead of data.
  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr & RANGE_MASK) != 32'h0000_0000);
  endfunction

  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_nxt_s;
  logic        if_win_s;
  logic        ls_win_s;
  logic        if_fault_s;
  logic        ls_fault_s;
  logic [31:0] rom_addr_s;
  logic        if_rvalid_r;
  logic [31:0] if_rdata_r;
  logic        if_err_r;
  logic        ls_rvalid_r;
  logic [31:0] ls_rdata_r;
  logic        ls_err_r;

  // Grant decision: load has priority unless fetch has been starved to the limit.
  always_comb begin
    if_win_s = 1'b0;
    ls_win_s = 1'b0;
    if (if_req && (!ls_req || (starve_cnt_r == STARVE_LIMIT))) begin
      if_win_s = 1'b1;
    end else if (ls_req) begin
      ls_win_s = 1'b1;
    end else begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end
  end

  // ROM address follows whichever port is granted this cycle.
  always_comb begin
    rom_addr_s = 32'h0000_0000;
    case ({if_win_s, ls_win_s})
      2'b10:   rom_addr_s = if_addr;
      2'b01:   rom_addr_s = ls_addr;
      default: rom_addr_s = 32'h0000_0000;
    endcase
  end

  // Consecutive fetch losses; any fetch grant or a dropped fetch request clears it.
  always_comb begin
    starve_nxt_s = 4'd0;
    if (if_req && !if_win_s) begin
      if (starve_cnt_r >= STARVE_LIMIT) begin
        starve_nxt_s = STARVE_LIMIT;
      end else begin
        starve_nxt_s = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_nxt_s = 4'd0;
    end
  end

  assign if_fault_s = addr_fault(if_addr);
  assign ls_fault_s = addr_fault(ls_addr);

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Fetch response: rdata/err only move on a grant, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      if_err_r    <= 1'b0;
    end else begin
      if_rvalid_r <= if_win_s;
      if (if_win_s) begin
        if_err_r   <= if_fault_s;
        if_rdata_r <= if_fault_s ? 32'h0000_0000 : rom_data;
      end
    end
  end

  // Load response, same scheme as fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_rvalid_r <= 1'b0;
      ls_rdata_r  <= 32'h0000_0000;
      ls_err_r    <= 1'b0;
    end else begin
      ls_rvalid_r <= ls_win_s;
      if (ls_win_s) begin
        ls_err_r   <= ls_fault_s;
        ls_rdata_r <= ls_fault_s ? 32'h0000_0000 : rom_data;
      end
    end
  end

  assign if_gnt    = if_win_s;
  assign ls_gnt    = ls_win_s;
  assign rom_addr  = rom_addr_s;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign if_err    = if_err_r;
  assign ls_rvalid = ls_rvalid_r;
  assign ls_rdata  = ls_rdata_r;
  assign ls_err    = ls_err_r;

endmodule
